saes_enc_ctrl: RTL

SAES_ENC_CTRL -- requirements
Module: saes_enc_ctrl

---
 rtl/saes_pkg.sv | 30 +++
 rtl/sbox.sv | 37 +++
 rtl/saes_enc_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/saes_pkg.sv
// ---------------------------------------------------------------------------
// saes_pkg
// Shared Simplified-AES definitions used by the encryption controller:
//   RCON1, RCON2 : round constants folded into the first word of K1 and K2
//   state_t      : controller FSM states (IDLE, RND1, RND2, DONE)
//   gf_mul4      : multiply a GF(2^4) element by 4 (x^2), modulus x^4+x+1
// ---------------------------------------------------------------------------
package saes_pkg;

  localparam logic [7:0] RCON1 = 8'h80;
  localparam logic [7:0] RCON2 = 8'h30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RND1 = 2'd1,
    RND2 = 2'd2,
    DONE = 2'd3
  } state_t;

  // Multiplying by x^2 shifts the nibble left by two. The bits pushed out
  // at x^4 and x^5 are folded back using x^4 = x+1 and x^5 = x^2+x.
  function automatic logic [3:0] gf_mul4(input logic [3:0] a);
    logic [3:0] r;
    r = {a[1:0], 2'b00}
        ^ (a[3] ? 4'h6 : 4'h0)
        ^ (a[2] ? 4'h3 : 4'h0);
    return r;
  endfunction

endpackage

// File: rtl/sbox.sv
// ---------------------------------------------------------------------------
// sbox
// Standard S-AES 4-bit substitution box, purely combinational.
//   nib : 4-bit input nibble
//   sub : substituted nibble
// ---------------------------------------------------------------------------
module sbox (
  input  logic [3:0] nib,
  output logic [3:0] sub
);

  // Table lookup; the default assignment keeps the block latch-free even
  // though every input code is listed.
  always_comb begin
    sub = 4'h0;
    case (nib)
      4'h0: sub = 4'h9;
      4'h1: sub = 4'h4;
      4'h2: sub = 4'hA;
      4'h3: sub = 4'hB;
      4'h4: sub = 4'hD;
      4'h5: sub = 4'h1;
      4'h6: sub = 4'h8;
      4'h7: sub = 4'h5;
      4'h8: sub = 4'h6;
      4'h9: sub = 4'h2;
      4'hA: sub = 4'h0;
      4'hB: sub = 4'h3;
      4'hC: sub = 4'hC;
      4'hD: sub = 4'hE;
      4'hE: sub = 4'hF;
      4'hF: sub = 4'h7;
      default: sub = 4'h0;
    endcase
  end

endmodule

// File: rtl/saes_enc_ctrl.sv
// ---------------------------------------------------------------------------
// saes_enc_ctrl
// Iterative Simplified-AES encryptor: one round per cycle, round keys
// derived on the fly from the previous round key.
//   clk, rst    : clock and synchronous active-high reset
//   in_valid    : plaintext/key pair offered
//   in_ready    : pair accepted this cycle (only in IDLE)
//   plaintext   : 16-bit block, n0=[15:12] .. n3=[3:0]
//   key         : 16-bit key, w0=[15:8], w1=[7:0]
//   out_valid   : ciphertext valid (DONE), held until out_ready
//   out_ready   : consumer accepts ciphertext
//   ciphertext  : encrypted block, forced to 0 while out_valid is low
//   busy        : high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module saes_enc_ctrl
  import saes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] plaintext,
  input  logic [15:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] ciphertext,
  output logic        busy
);

  state_t      state;
  state_t      state_next;
  logic [15:0] st;
  logic [15:0] rk;
  logic        accept;

  logic [15:0] sub_st;
  logic [15:0] shift_st;
  logic [15:0] mix_st;
  logic [3:0]  sub_k_hi;
  logic [3:0]  sub_k_lo;
  logic [7:0]  rcon;
  logic [7:0]  w_even;
  logic [7:0]  w_odd;
  logic [15:0] round_key;

  // NibSub on the four state nibbles.
  sbox u_sbox_n0 (.nib(st[15:12]), .sub(sub_st[15:12]));
  sbox u_sbox_n1 (.nib(st[11:8]),  .sub(sub_st[11:8]));
  sbox u_sbox_n2 (.nib(st[7:4]),   .sub(sub_st[7:4]));
  sbox u_sbox_n3 (.nib(st[3:0]),   .sub(sub_st[3:0]));

  // SubNib(RotNib(.)) on the low key word. In RND1 rk[7:0] is w1, in RND2
  // it is w3 (rk then holds K1), so one pair of boxes serves both rounds.
  sbox u_sbox_k0 (.nib(rk[3:0]), .sub(sub_k_hi));
  sbox u_sbox_k1 (.nib(rk[7:4]), .sub(sub_k_lo));

  // Round-key and round-function datapath. ShiftRow swaps n1 and n3;
  // MixCol treats (n0,n1) and (n2,n3) as columns times [[1,4],[4,1]].
  always_comb begin
    rcon      = (state == RND2) ? RCON2 : RCON1;
    w_even    = rk[15:8] ^ rcon ^ {sub_k_hi, sub_k_lo};
    w_odd     = w_even ^ rk[7:0];
    round_key = {w_even, w_odd};

    shift_st  = {sub_st[15:12], sub_st[3:0], sub_st[7:4], sub_st[11:8]};
    mix_st    = {shift_st[15:12] ^ gf_mul4(shift_st[11:8]),
                 gf_mul4(shift_st[15:12]) ^ shift_st[11:8],
                 shift_st[7:4] ^ gf_mul4(shift_st[3:0]),
                 gf_mul4(shift_st[7:4]) ^ shift_st[3:0]};
  end

  // FSM state register; reset wins over any accept in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. DONE leaves on out_ready but never
  // raises in_ready, so a new pair can only be taken one cycle later.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_next = RND1;
        end
      end
      RND1: state_next = RND2;
      RND2: state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept     = in_valid & in_ready;
  assign ciphertext = out_valid ? st : 16'h0000;

  // Cipher state and round-key registers. Inputs are only sampled on an
  // accept, so plaintext/key may change freely while a block is in flight.
  // rk keeps K1 through RND2 because K2 is derived from it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= 16'h0000;
      rk <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            st <= plaintext ^ key;
            rk <= key;
          end
        end
        RND1: begin
          st <= mix_st ^ round_key;
          rk <= round_key;
        end
        RND2: begin
          st <= shift_st ^ round_key;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
